// File: rtl/fft_rd_addr_gen_if.sv
// Control/RAM-side signal bundle for fft_rd_addr_gen.
// The master side is the FFT control FSM plus RAM rd_ready; the slave side is the sequencer.
interface fft_rd_addr_gen_if #(
   parameter int MAX_LOG2N = 10
);
   localparam int LW = $clog2(MAX_LOG2N + 1);

   logic                 start;
   logic                 abort;
   logic [LW-1:0]        cfg_log2n;
   logic                 cfg_nat_ord;
   logic                 rd_ready;
   logic                 busy;
   logic                 rd_en;
   logic [MAX_LOG2N-1:0] rd_addr;
   logic                 rd_sel;
   logic [MAX_LOG2N-2:0] rd_tw_addr;
   logic [LW-1:0]        stage;
   logic                 first_stage;
   logic                 last_stage;
   logic                 out_pass;
   logic                 stage_done;
   logic                 done;
   logic                 cfg_err;

   modport master (
      output start, abort, cfg_log2n, cfg_nat_ord, rd_ready,
      input  busy, rd_en, rd_addr, rd_sel, rd_tw_addr, stage, first_stage,
             last_stage, out_pass, stage_done, done, cfg_err
   );

   modport slave (
      input  start, abort, cfg_log2n, cfg_nat_ord, rd_ready,
      output busy, rd_en, rd_addr, rd_sel, rd_tw_addr, stage, first_stage,
             last_stage, out_pass, stage_done, done, cfg_err
   );
endinterface

// File: rtl/fft_rd_addr_gen.sv
// Radix-2 in-place FFT read-address sequencer: per butterfly it issues the top then bottom
// RAM address plus the twiddle index. Define FFT_RD_BITREV_EN for the bit-reversed readout pass.
module fft_rd_addr_gen #(
   parameter int MAX_LOG2N = 10,
   parameter int STAGE_GAP = 4
) (
   input logic              clk,
   input logic              rst_n,
   fft_rd_addr_gen_if.slave bus
);
   localparam int LW = $clog2(MAX_LOG2N + 1);
   localparam int AW = MAX_LOG2N;
   localparam int TW = MAX_LOG2N - 1;
   localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

`ifdef FFT_RD_BITREV_EN
   typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_DONE, S_OUT} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;
`endif

   state_t        state_q, state_d, resume_st;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [LW-1:0] stage_q, stage_d, l2_q, l2_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          nat_q, nat_d, out_req;
   logic          cnt_wrap, stage_last, sd_d, cerr_d;

   logic [TW-1:0] b_d, lo_t, tw_d;
   logic [AW-1:0] lo_a, addr_d;
   logic          run_d, out_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      stage_d    = stage_q;
      l2_d       = l2_q;
      gap_d      = gap_q;
      nat_d      = nat_q;
      sd_d       = 1'b0;
      cerr_d     = 1'b0;
      cnt_wrap   = (cnt_q == ~({AW{1'b1}} << l2_q));
      stage_last = (stage_q == (l2_q - LW'(1)));
`ifdef FFT_RD_BITREV_EN
      out_req    = nat_q;
      resume_st  = stage_last ? S_OUT : S_RUN;
`else
      out_req    = 1'b0;
      resume_st  = S_RUN;
`endif

      unique case (state_q)
         S_IDLE: if (bus.start) begin
            if (bus.cfg_log2n == '0 || bus.cfg_log2n > LW'(MAX_LOG2N)) begin
               cerr_d = 1'b1;
            end else begin
               l2_d    = bus.cfg_log2n;
`ifdef FFT_RD_BITREV_EN
               nat_d   = bus.cfg_nat_ord;
`endif
               stage_d = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         // rd_en is high throughout RUN, so rd_ready alone marks an issue.
         S_RUN: if (bus.rd_ready) begin
            if (!cnt_wrap) begin
               cnt_d = cnt_q + AW'(1);
            end else begin
               cnt_d = '0;
               sd_d  = 1'b1;
               if (stage_last && !out_req) begin
                  state_d = S_DONE;
               end else if (STAGE_GAP == 0) begin
                  stage_d = stage_q + LW'(1);
                  state_d = resume_st;
               end else begin
                  gap_d   = GW'(STAGE_GAP - 1);
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (gap_q == '0) begin
               stage_d = stage_q + LW'(1);
               state_d = resume_st;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
`ifdef FFT_RD_BITREV_EN
         S_OUT: if (bus.rd_ready) begin
            if (cnt_wrap) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (bus.abort) begin
         state_d = S_IDLE;
         sd_d    = 1'b0;
         cerr_d  = 1'b0;
      end
   end

   // Output datapath works on next-state values so every output comes straight off a flop.
   always_comb begin
      run_d = (state_d == S_RUN);
`ifdef FFT_RD_BITREV_EN
      out_d = (state_d == S_OUT);
`else
      out_d = 1'b0;
`endif
      b_d    = cnt_d[AW-1:1];
      lo_a   = ~({AW{1'b1}} << stage_d);
      lo_t   = ~({TW{1'b1}} << stage_d);
      tw_d   = '0;
      addr_d = '0;
      if (run_d) begin
         addr_d = (({1'b0, b_d} & ~lo_a) << 1) | ({{(AW-1){1'b0}}, cnt_d[0]} << stage_d)
                | ({1'b0, b_d} & lo_a);
         tw_d   = (b_d & lo_t) << (LW'(TW) - stage_d);
      end
`ifdef FFT_RD_BITREV_EN
      else if (out_d) begin
         for (int unsigned i = 0; i < AW; i++) addr_d[i] = cnt_d[AW-1-i];
         addr_d = addr_d >> (LW'(AW) - l2_d);
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         cnt_q           <= '0;
         stage_q         <= '0;
         l2_q            <= '0;
         gap_q           <= '0;
         nat_q           <= 1'b0;
         bus.busy        <= 1'b0;
         bus.rd_en       <= 1'b0;
         bus.rd_addr     <= '0;
         bus.rd_sel      <= 1'b0;
         bus.rd_tw_addr  <= '0;
         bus.stage       <= '0;
         bus.first_stage <= 1'b0;
         bus.last_stage  <= 1'b0;
         bus.out_pass    <= 1'b0;
         bus.stage_done  <= 1'b0;
         bus.done        <= 1'b0;
         bus.cfg_err     <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         stage_q         <= stage_d;
         l2_q            <= l2_d;
         gap_q           <= gap_d;
         nat_q           <= nat_d;
         bus.busy        <= (state_d != S_IDLE);
         bus.rd_en       <= run_d | out_d;
         bus.rd_addr     <= addr_d;
         bus.rd_sel      <= run_d & cnt_d[0];
         bus.rd_tw_addr  <= tw_d;
         bus.stage       <= (state_d == S_IDLE) ? '0 : stage_d;
         bus.first_stage <= run_d && (stage_d == '0);
         bus.last_stage  <= run_d && (stage_d == (l2_d - LW'(1)));
         bus.out_pass    <= out_d;
         bus.stage_done  <= sd_d;
         bus.done        <= (state_d == S_DONE);
         bus.cfg_err     <= cerr_d;
      end
   end
endmodule

// File: tb/tb_fft_rd_addr_gen.sv
// Bench for fft_rd_addr_gen at MAX_LOG2N=3: the STAGE_GAP=0 instance is scoreboarded per read,
// the STAGE_GAP=4 instance is checked for gap length, pulse counts and run time.
`timescale 1ns/1ps
module tb_fft_rd_addr_gen;
   localparam int M    = 3;
   localparam int LW   = $clog2(M + 1);
   localparam int GAP1 = 4;
`ifdef FFT_RD_BITREV_EN
   localparam bit BITREV = 1'b1;
`else
   localparam bit BITREV = 1'b0;
`endif
   localparam int HAND_ADDR [24] = '{0,1,2,3,4,5,6,7, 0,2,1,3,4,6,5,7, 0,4,1,5,2,6,3,7};
   localparam int HAND_TW   [24] = '{0,0,0,0,0,0,0,0, 0,0,2,2,0,0,2,2, 0,0,1,1,2,2,3,3};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fft_rd_addr_gen_if #(.MAX_LOG2N(M)) b0 ();
   fft_rd_addr_gen_if #(.MAX_LOG2N(M)) b1 ();

   fft_rd_addr_gen #(.MAX_LOG2N(M), .STAGE_GAP(0))    dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   fft_rd_addr_gen #(.MAX_LOG2N(M), .STAGE_GAP(GAP1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

   int n_chk = 0, n_fail = 0;
   int sd0 = 0, dn0 = 0, sd1 = 0, dn1 = 0, low1 = 0;
   logic [31:0] sbq [$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack(input int addr, input int tw, input int sel, input int stg,
                                        input bit fs, input bit ls, input bit op);
      return 32'((addr << 12) | (tw << 8) | (sel << 7) | (stg << 4)
                 | (int'(fs) << 2) | (int'(ls) << 1) | int'(op));
   endfunction

   function automatic logic [31:0] all_outs();
      return {b0.busy, b0.rd_en, b0.rd_addr, b0.rd_sel, b0.rd_tw_addr, b0.stage, b0.first_stage,
              b0.last_stage, b0.out_pass, b0.stage_done, b0.done, b0.cfg_err,
              b1.busy, b1.rd_en, b1.rd_addr, b1.rd_sel, b1.rd_tw_addr, b1.stage, b1.first_stage,
              b1.last_stage, b1.out_pass, b1.stage_done, b1.done, b1.cfg_err};
   endfunction

   function automatic int brev(input int v, input int w);
      int r = 0;
      for (int k = 0; k < w; k++) if (((v >> k) & 1) != 0) r |= 1 << (w - 1 - k);
      return r;
   endfunction

   // Expected reads: butterfly blocks of width 2*span, top at blk*2*span+j, bottom at top+span.
   task automatic push_exp(input int l2, input bit nat);
      int n, span, top, tw;
      n = 1 << l2;
      if (l2 == 3) begin
         for (int i = 0; i < 24; i++)
            sbq.push_back(pack(HAND_ADDR[i], HAND_TW[i], i % 2, i / 8, i < 8, i >= 16, 1'b0));
      end else begin
         for (int s = 0; s < l2; s++) begin
            span = 1 << s;
            for (int blk = 0; blk < n / (2 * span); blk++) begin
               for (int j = 0; j < span; j++) begin
                  top = blk * 2 * span + j;
                  tw  = j << (M - 1 - s);
                  sbq.push_back(pack(top, tw, 0, s, s == 0, s == l2 - 1, 1'b0));
                  sbq.push_back(pack(top + span, tw, 1, s, s == 0, s == l2 - 1, 1'b0));
               end
            end
         end
      end
      if (BITREV && nat)
         for (int c = 0; c < n; c++) sbq.push_back(pack(brev(c, l2), 0, 0, l2, 1'b0, 1'b0, 1'b1));
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (b0.rd_en) begin
            if (sbq.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL sb_unexpected: got read addr 0x%0h, expected no read at %0t",
                        b0.rd_addr, $time);
            end else if (b0.rd_ready) begin
               check("issue", pack(int'(b0.rd_addr), int'(b0.rd_tw_addr), int'(b0.rd_sel),
                     int'(b0.stage), b0.first_stage, b0.last_stage, b0.out_pass), sbq[0]);
               void'(sbq.pop_front());
            end else begin
               check("stall_hold", pack(int'(b0.rd_addr), int'(b0.rd_tw_addr), int'(b0.rd_sel),
                     int'(b0.stage), b0.first_stage, b0.last_stage, b0.out_pass), sbq[0]);
            end
         end
         if (b0.stage_done) sd0++;
         if (b0.done)       dn0++;
         if (b1.stage_done) sd1++;
         if (b1.done)       dn1++;
         if (b1.busy && !b1.rd_en) begin
            low1++;
         end else begin
            if (b1.rd_en && low1 > 0) check("stage_gap", low1, GAP1);
            low1 = 0;
         end
      end
   end

   task automatic run(input int l2, input int stall_at, input bit nat);
      int n, cyc, c0, c1, iss, stall_left, e0, e1;
      int sd0b, dn0b, sd1b, dn1b;
      bit stalled;
      n    = 1 << l2;
      sd0b = sd0; dn0b = dn0; sd1b = sd1; dn1b = dn1;
      push_exp(l2, nat);
      @(posedge clk); #1;
      b0.start = 1'b1; b0.cfg_log2n = LW'(l2); b0.cfg_nat_ord = nat;
      b1.start = 1'b1; b1.cfg_log2n = LW'(l2); b1.cfg_nat_ord = nat;
      @(posedge clk); #1;
      b0.start = 1'b0; b1.start = 1'b0;
      c0 = -1; c1 = -1; cyc = 0; iss = 0; stall_left = 0; stalled = 1'b0;
      while ((c0 < 0 || c1 < 0) && cyc < 400) begin
         if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) b0.rd_ready = 1'b1;
         end else if (!stalled && stall_at >= 0 && iss == stall_at) begin
            b0.rd_ready = 1'b0;
            stall_left  = 3;
            stalled     = 1'b1;
         end
         if (b0.rd_en && b0.rd_ready) iss++;
         @(posedge clk); #1;
         cyc++;
         if (b0.done && c0 < 0) c0 = cyc;
         if (b1.done && c1 < 0) c1 = cyc;
      end
      e0 = l2 * n + (stall_at >= 0 ? 3 : 0) + ((BITREV && nat) ? n : 0);
      e1 = l2 * n + (l2 - 1) * GAP1 + ((BITREV && nat) ? GAP1 + n : 0);
      check("run_time_gap0", c0, e0);
      check("run_time_gap4", c1, e1);
      repeat (2) @(posedge clk); #1;
      check("sb_drained", sbq.size(), 0);
      check("idle_after_run", {b0.busy, b1.busy}, 2'b00);
      check("stage_done_cnt0", sd0 - sd0b, l2);
      check("done_cnt0", dn0 - dn0b, 1);
      check("stage_done_cnt1", sd1 - sd1b, l2);
      check("done_cnt1", dn1 - dn1b, 1);
   endtask

   task automatic cfg_err_test(input int v);
      @(posedge clk); #1;
      b0.start = 1'b1; b0.cfg_log2n = LW'(v);
      @(posedge clk); #1;
      b0.start = 1'b0;
      check("cfg_err_pulse", {b0.cfg_err, b0.busy}, 2'b10);
      @(posedge clk); #1;
      check("cfg_err_clear", {b0.cfg_err, b0.busy}, 2'b00);
   endtask

   task automatic abort_test();
      int t, sdb, dnb;
      t = 0;
      push_exp(3, 1'b0);
      @(posedge clk); #1;
      b0.start = 1'b1; b0.cfg_log2n = LW'(3); b0.cfg_nat_ord = 1'b0;
      @(posedge clk); #1;
      b0.start = 1'b0;
      while (b0.stage != LW'(1) && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      check("abort_reach_stage1", b0.stage, 1);
      repeat (2) @(posedge clk); #1;
      sdb = sd0; dnb = dn0;
      b0.abort = 1'b1;
      @(posedge clk); #1;
      b0.abort = 1'b0;
      check("abort_idle", {b0.busy, b0.rd_en, b0.stage_done, b0.done}, 4'b0000);
      sbq.delete();
      repeat (10) @(posedge clk); #1;
      check("abort_no_stage_done", sd0 - sdb, 0);
      check("abort_no_done", dn0 - dnb, 0);
   endtask

   task automatic reset_mid_run();
      push_exp(3, 1'b0);
      @(posedge clk); #1;
      b0.start = 1'b1; b0.cfg_log2n = LW'(3);
      b1.start = 1'b1; b1.cfg_log2n = LW'(3);
      @(posedge clk); #1;
      b0.start = 1'b0; b1.start = 1'b0;
      repeat (5) @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("reset_mid_run", all_outs(), '0);
      sbq.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      b0.start = 1'b0; b0.abort = 1'b0; b0.cfg_log2n = '0; b0.cfg_nat_ord = 1'b0; b0.rd_ready = 1'b1;
      b1.start = 1'b0; b1.abort = 1'b0; b1.cfg_log2n = '0; b1.cfg_nat_ord = 1'b0; b1.rd_ready = 1'b1;
      repeat (3) @(posedge clk); #1;
      check("reset_outputs", all_outs(), '0);
      rst_n = 1'b1;
      run(3, -1, 1'b0);
      run(3, 10, 1'b0);
      run(1, -1, 1'b0);
      run(2, -1, 1'b0);
      run(3, -1, 1'b1);
      cfg_err_test(0);
      cfg_err_test(4);
      abort_test();
      reset_mid_run();
      run(2, -1, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end of test, expected finish before %0t", $time);
      $fatal(1);
   end
endmodule
